// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl.
// The pipeline side uses master and drives stall requests and branch
// resolution. The controller side uses slave and drives the hold
// vector, the flush strobes and the PC redirect.
interface pipe_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              stallreq_if;
  logic              stallreq_id;
  logic              stallreq_mem;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic [5:0]        stall;
  logic              flush_ifid;
  logic              flush_idex;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output stallreq_if, stallreq_id, stallreq_mem, branch_flag_i, branch_target_i,
    input  stall, flush_ifid, flush_idex, redirect_valid, redirect_pc
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_mem, branch_flag_i, branch_target_i,
    output stall, flush_ifid, flush_idex, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merging, branch flush and PC redirect sequencing for
// the 5-stage RV32 pipeline. When the fetch port is busy, a taken branch
// is parked in PEND until the port can accept the redirect.
// Optional feature macro: PIPE_CTRL_PERF_EN adds saturating stall_cycles
// and flush_count performance counters of width CNT_W.
module pipe_ctrl #(
  parameter int unsigned ADDR_W = 32
`ifdef PIPE_CTRL_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  pipe_ctrl_if.slave         bus
`ifdef PIPE_CTRL_PERF_EN
  , output logic [CNT_W-1:0] stall_cycles
  , output logic [CNT_W-1:0] flush_count
`endif
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pend_pc, pend_pc_n;
  logic              br_take;
  logic [5:0]        stall_c;
  logic              flush_ifid_c, flush_idex_c, redirect_valid_c;
  logic [ADDR_W-1:0] redirect_pc_c;

  // A MEM stall holds EX, so the branch is accepted only once MEM is free.
  assign br_take = bus.branch_flag_i & ~bus.stallreq_mem;

  // State and pending target register; reset drops any pending redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pend_pc <= '0;
    end else begin
      state   <= state_n;
      pend_pc <= pend_pc_n;
    end
  end

  // Stall priority, flush/redirect outputs and next-state selection.
  always_comb begin
    state_n          = state;
    pend_pc_n        = pend_pc;
    stall_c          = '0;
    flush_ifid_c     = 1'b0;
    flush_idex_c     = 1'b0;
    redirect_valid_c = 1'b0;
    redirect_pc_c    = '0;

    if (bus.stallreq_mem)      stall_c = 6'b011111;
    else if (bus.stallreq_id)  stall_c = 6'b000111;
    else if (bus.stallreq_if)  stall_c = 6'b000011;

    unique case (state)
      IDLE: begin
        if (br_take) begin
          flush_ifid_c = 1'b1;
          flush_idex_c = 1'b1;
          if (!bus.stallreq_if) begin
            redirect_valid_c = 1'b1;
            redirect_pc_c    = bus.branch_target_i;
          end else begin
            pend_pc_n = bus.branch_target_i;
            state_n   = PEND;
          end
        end
      end
      PEND: begin
        // Keep discarding the wrong-path fetch until the redirect lands.
        flush_ifid_c  = 1'b1;
        redirect_pc_c = pend_pc;
        if (br_take) begin
          pend_pc_n     = bus.branch_target_i;
          redirect_pc_c = bus.branch_target_i;
        end
        if (!bus.stallreq_if && !bus.stallreq_mem) begin
          redirect_valid_c = 1'b1;
          state_n          = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are forced quiet for as long as reset is asserted.
    if (!rst) begin
      stall_c          = '0;
      flush_ifid_c     = 1'b0;
      flush_idex_c     = 1'b0;
      redirect_valid_c = 1'b0;
      redirect_pc_c    = '0;
    end
  end

  assign bus.stall          = stall_c;
  assign bus.flush_ifid     = flush_ifid_c;
  assign bus.flush_idex     = flush_idex_c;
  assign bus.redirect_valid = redirect_valid_c;
  assign bus.redirect_pc    = redirect_pc_c;

`ifdef PIPE_CTRL_PERF_EN
  // Saturating counters of held-PC cycles and accepted branches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_c[0] && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (br_take && (flush_count != '1))     flush_count  <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a behavioural model predicts all
// outputs every cycle, and directed vectors pin hand-computed values.
module tb_pipe_ctrl;

  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pipe_ctrl_if #(.ADDR_W(32)) bus ();

`ifdef PIPE_CTRL_PERF_EN
  logic [CW-1:0] stall_cycles, flush_count;
  pipe_ctrl #(.ADDR_W(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
`else
  pipe_ctrl #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: at most one outstanding redirect target awaiting the fetch port.
  bit            m_pend;
  logic [31:0]   m_tgt;
  int unsigned   m_stall_cnt, m_flush_cnt;

  function automatic logic [5:0] want_stall();
    if (!rst) return 6'd0;
    if (bus.stallreq_mem) return 6'b011111;
    if (bus.stallreq_id)  return 6'b000111;
    if (bus.stallreq_if)  return 6'b000011;
    return 6'd0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend      <= 1'b0;
      m_tgt       <= '0;
      m_stall_cnt <= 0;
      m_flush_cnt <= 0;
    end else begin
      if (want_stall() != 6'd0 && m_stall_cnt < (2**CW - 1)) m_stall_cnt <= m_stall_cnt + 1;
      if (bus.branch_flag_i && !bus.stallreq_mem) begin
        if (m_flush_cnt < (2**CW - 1)) m_flush_cnt <= m_flush_cnt + 1;
        if (!m_pend) begin
          if (bus.stallreq_if) begin
            m_pend <= 1'b1;
            m_tgt  <= bus.branch_target_i;
          end
        end else begin
          m_tgt <= bus.branch_target_i;
          if (!bus.stallreq_if) m_pend <= 1'b0;
        end
      end else if (m_pend && !bus.stallreq_if && !bus.stallreq_mem) begin
        m_pend <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic take, fi, fe, rv;
    logic [31:0] pc;
    take = bus.branch_flag_i & ~bus.stallreq_mem;
    fi = 0; fe = 0; rv = 0; pc = 0;
    if (rst) begin
      if (!m_pend) begin
        fi = take; fe = take;
        rv = take & ~bus.stallreq_if;
        pc = rv ? bus.branch_target_i : 32'd0;
      end else begin
        fi = 1;
        rv = ~bus.stallreq_if & ~bus.stallreq_mem;
        pc = take ? bus.branch_target_i : m_tgt;
      end
    end
    chk("stall", 64'(bus.stall), 64'(want_stall()));
    chk("flush_ifid", 64'(bus.flush_ifid), 64'(fi));
    chk("flush_idex", 64'(bus.flush_idex), 64'(fe));
    chk("redirect_valid", 64'(bus.redirect_valid), 64'(rv));
    chk("redirect_pc", 64'(bus.redirect_pc), 64'(pc));
`ifdef PIPE_CTRL_PERF_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall_cnt));
    chk("flush_count", 64'(flush_count), 64'(m_flush_cnt));
`endif
  end

  // Apply one input vector for the coming cycle, shortly after the edge.
  task automatic drive(input logic sif, input logic sid, input logic smem,
                       input logic bf, input logic [31:0] bt);
    @(posedge clk);
    #1;
    bus.stallreq_if     = sif;
    bus.stallreq_id     = sid;
    bus.stallreq_mem    = smem;
    bus.branch_flag_i   = bf;
    bus.branch_target_i = bt;
    #1;
  endtask

  initial begin
    bus.stallreq_if = 1; bus.stallreq_id = 1; bus.stallreq_mem = 1;
    bus.branch_flag_i = 1; bus.branch_target_i = 32'h44;
    #2;
    chk("reset_stall", 64'(bus.stall), 64'h0);
    chk("reset_redirect_pc", 64'(bus.redirect_pc), 64'h0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;

    // Stall priority
    drive(1, 1, 1, 0, 0); chk("prio_all", 64'(bus.stall), 64'h1f);
    drive(1, 1, 0, 0, 0); chk("prio_id", 64'(bus.stall), 64'h07);
    drive(1, 0, 0, 0, 0); chk("prio_if", 64'(bus.stall), 64'h03);
    drive(0, 0, 0, 0, 0); chk("prio_none", 64'(bus.stall), 64'h00);

    // Immediate branch
    drive(0, 0, 0, 1, 32'h80);
    chk("imm_rv", 64'(bus.redirect_valid), 64'h1);
    chk("imm_pc", 64'(bus.redirect_pc), 64'h80);
    chk("imm_fe", 64'(bus.flush_idex), 64'h1);
    drive(0, 0, 0, 0, 0);
    chk("imm_after_rv", 64'(bus.redirect_valid), 64'h0);
    chk("imm_after_fi", 64'(bus.flush_ifid), 64'h0);

    // Pending redirect
    drive(1, 0, 0, 1, 32'h100);
    chk("pend0_fe", 64'(bus.flush_idex), 64'h1);
    chk("pend0_rv", 64'(bus.redirect_valid), 64'h0);
    for (int i = 1; i <= 2; i++) begin
      drive(1, 0, 0, 0, 0);
      chk("pend_fi", 64'(bus.flush_ifid), 64'h1);
      chk("pend_rv", 64'(bus.redirect_valid), 64'h0);
    end
    drive(0, 0, 0, 0, 0);
    chk("pend3_rv", 64'(bus.redirect_valid), 64'h1);
    chk("pend3_pc", 64'(bus.redirect_pc), 64'h100);
    drive(0, 0, 0, 0, 0);
    chk("pend_idle_fi", 64'(bus.flush_ifid), 64'h0);

    // MEM-blocked branch
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 1, 32'h40);
      chk("memblk_fi", 64'(bus.flush_ifid), 64'h0);
      chk("memblk_rv", 64'(bus.redirect_valid), 64'h0);
      chk("memblk_stall", 64'(bus.stall), 64'h1f);
    end
    drive(0, 0, 0, 1, 32'h40);
    chk("memblk_pc", 64'(bus.redirect_pc), 64'h40);
    chk("memblk_rv2", 64'(bus.redirect_valid), 64'h1);

    // Branch overwriting a pending target in the redirect cycle
    drive(1, 0, 0, 1, 32'h300);
    drive(0, 0, 0, 1, 32'h340);
    chk("ovr_pc", 64'(bus.redirect_pc), 64'h340);
    chk("ovr_fe", 64'(bus.flush_idex), 64'h0);
    drive(0, 0, 0, 0, 0);
    chk("ovr_done", 64'(bus.redirect_valid), 64'h0);

    // Reset asserted mid-PEND
    drive(1, 0, 0, 1, 32'h200);
    drive(1, 0, 0, 0, 0);
    chk("rstp_fi", 64'(bus.flush_ifid), 64'h1);
    #1 rst = 1'b0;
    #1;
    chk("rstp_fi0", 64'(bus.flush_ifid), 64'h0);
    chk("rstp_pc0", 64'(bus.redirect_pc), 64'h0);
    chk("rstp_stall0", 64'(bus.stall), 64'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("rstp_rv", 64'(bus.redirect_valid), 64'h0);
    chk("rstp_pc", 64'(bus.redirect_pc), 64'h0);

`ifdef PIPE_CTRL_PERF_EN
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h10);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h20);
    drive(0, 0, 0, 0, 0);
    chk("perf_stall5", 64'(stall_cycles), 64'h5);
    chk("perf_flush2", 64'(flush_count), 64'h2);
    for (int i = 0; i < 12; i++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("perf_sat", 64'(stall_cycles), 64'hf);
`endif

    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
